// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: FSM states, opcode/funct
// values, datapath select codes and the control-word bundle.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       fault;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // R-type is only legal for the five ALU functions the datapath implements.
  function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Moore output decode: maps the FSM state and the latched opcode onto the
// datapath control word.
module mc_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_q,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_IF: begin
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      // ALU precomputes the branch target while the register file is read.
      S_ID: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_BRANCH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_EX: begin
        case (op_q)
          OP_RTYPE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNCT;
          end
          OP_LW, OP_SW, OP_ADDI: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
          end
          OP_BEQ: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_src        = PCSRC_ALUOUT;
          end
          OP_J: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PCSRC_JUMP;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.mem_read  = (op_q == OP_LW);
        ctrl.mem_write = (op_q == OP_SW);
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (op_q == OP_RTYPE);
        ctrl.mem_to_reg = (op_q == OP_LW);
      end
      S_ERR: ctrl.fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS-style controller: IF/ID/EX/MEM/WB FSM with a data-memory
// timeout, a sticky error state and saturating cycle/instruction counters.
module mc_control
  import mc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             START,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             DM_Ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUOp,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] InstrCount,
  output logic             Fault
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic [TW-1:0]    mem_cnt;
  logic             mem_timeout;
  logic             retire;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
  ctrl_t            dec, ctrl;

  // Zero only qualifies PCWriteCond inside the datapath; the FSM never needs it.
  logic unused_zero;
  assign unused_zero = Zero;

  always_ff @(posedge CLK or negedge START) begin
    if (!START) begin
      state_q <= S_IF;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= Op;
    end
  end

  assign mem_timeout = (mem_cnt == TW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: state_d = instr_legal(Op, Funct) ? S_EX : S_ERR;
      S_EX: begin
        case (op_q)
          OP_RTYPE, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:      state_d = S_MEM;
          OP_BEQ, OP_J:      state_d = S_IF;
          default:           state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        if (DM_Ready)         state_d = (op_q == OP_LW) ? S_WB : S_IF;
        else if (mem_timeout) state_d = S_ERR;
      end
      S_WB:    state_d = S_IF;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  mc_decode u_decode (
    .state (state_q),
    .op_q  (op_q),
    .ctrl  (dec)
  );

  // Outputs are forced low combinationally so a falling START kills a write instantly.
  assign ctrl = START ? dec : CTRL_IDLE;

  assign IRWrite     = ctrl.ir_write;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSrc       = ctrl.pc_src;
  assign ALUOp       = ctrl.alu_op;
  assign Fault       = ctrl.fault;

  always_ff @(posedge CLK or negedge START) begin
    if (!START)                 mem_cnt <= '0;
    else if (state_q != S_MEM)  mem_cnt <= '0;
    else if (!DM_Ready)         mem_cnt <= mem_cnt + TW'(1);
  end

  assign retire = (state_q == S_EX || state_q == S_MEM || state_q == S_WB) &&
                  (state_d == S_IF);

  always_ff @(posedge CLK or negedge START) begin
    if (!START) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (cycle_cnt != '1)           cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire && instr_cnt != '1) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign CycleCount = cycle_cnt;
  assign InstrCount = instr_cnt;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus queues hand-computed control words
// per cycle, a negedge monitor pops and compares them against the DUT.
module tb_mc_control;

  localparam int CW = 8;
  localparam int W  = 16 + 2 * CW;

  localparam logic [15:0] C_RST     = 16'h0000;
  localparam logic [15:0] C_IF      = 16'hC020;
  localparam logic [15:0] C_ID      = 16'h0060;
  localparam logic [15:0] C_EX_R    = 16'h0084;
  localparam logic [15:0] C_EX_I    = 16'h00C0;
  localparam logic [15:0] C_EX_BEQ  = 16'h208A;
  localparam logic [15:0] C_EX_J    = 16'h4010;
  localparam logic [15:0] C_MEM_LW  = 16'h0200;
  localparam logic [15:0] C_MEM_SW  = 16'h0100;
  localparam logic [15:0] C_WB_R    = 16'h1800;
  localparam logic [15:0] C_WB_LW   = 16'h1400;
  localparam logic [15:0] C_WB_ADDI = 16'h1000;
  localparam logic [15:0] C_ERR     = 16'h0001;

  logic          CLK, START, Zero, DM_Ready;
  logic [5:0]    Op, Funct;
  logic          IRWrite, PCWrite, PCWriteCond, RegWrite, RegDst, MemtoReg;
  logic          MemRead, MemWrite, ALUSrcA, Fault;
  logic [1:0]    ALUSrcB, PCSrc, ALUOp;
  logic [CW-1:0] CycleCount, InstrCount;

  logic [W-1:0]  expq[$];
  string         nameq[$];
  logic [W-1:0]  mon_v;
  string         mon_name;
  logic [W-1:0]  obs;
  logic [CW-1:0] cyc_exp, ins_exp;
  int            n_cmp, n_fail;

  mc_control #(.CNT_W(CW), .MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .START(START), .Op(Op), .Funct(Funct), .Zero(Zero),
    .DM_Ready(DM_Ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .CycleCount(CycleCount), .InstrCount(InstrCount), .Fault(Fault)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  assign obs = {IRWrite, PCWrite, PCWriteCond, RegWrite, RegDst, MemtoReg,
                MemRead, MemWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp, Fault,
                CycleCount, InstrCount};

  task automatic checkOutput(input string name, input logic [W-1:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got ctrl=%h cyc=%0d ins=%0d, want ctrl=%h cyc=%0d ins=%0d",
               name, obs[W-1 -: 16], obs[2*CW-1 -: CW], obs[CW-1:0],
               exp_v[W-1 -: 16], exp_v[2*CW-1 -: CW], exp_v[CW-1:0]);
    end
  endtask

  always @(negedge CLK) begin
    if (expq.size() != 0) begin
      mon_v    = expq.pop_front();
      mon_name = nameq.pop_front();
      checkOutput(mon_name, mon_v);
    end
  end

  // One clock cycle: drive inputs, queue the expected word, advance the model counters.
  task automatic applyStimulus(input string name, input logic [15:0] ctrl,
                               input bit retire, input logic dm);
    DM_Ready = dm;
    expq.push_back({ctrl, cyc_exp, ins_exp});
    nameq.push_back(name);
    @(posedge CLK);
    #1;
    if (START) begin
      if (cyc_exp != '1)           cyc_exp++;
      if (retire && ins_exp != '1) ins_exp++;
    end
  endtask

  task automatic setInstr(input logic [5:0] op, input logic [5:0] funct, input logic z);
    Op    = op;
    Funct = funct;
    Zero  = z;
  endtask

  task automatic doReset(input string name);
    START   = 1'b0;
    cyc_exp = '0;
    ins_exp = '0;
    applyStimulus(name, C_RST, 1'b0, 1'b1);
    START = 1'b1;
  endtask

  task automatic doJump(input string name);
    setInstr(6'b000010, 6'b000000, 1'b0);
    applyStimulus({name, " IF"}, C_IF, 1'b0, 1'b1);
    applyStimulus({name, " ID"}, C_ID, 1'b0, 1'b1);
    applyStimulus({name, " EX"}, C_EX_J, 1'b1, 1'b1);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    cyc_exp = '0; ins_exp = '0;
    START = 1'b0; DM_Ready = 1'b0;
    setInstr(6'b000000, 6'b000000, 1'b0);
    @(posedge CLK);
    #1;
    applyStimulus("reset hold 0", C_RST, 1'b0, 1'b0);
    applyStimulus("reset hold 1", C_RST, 1'b0, 1'b1);
    START = 1'b1;

    setInstr(6'b000000, 6'b100000, 1'b0);
    applyStimulus("add IF", C_IF, 1'b0, 1'b1);
    applyStimulus("add ID", C_ID, 1'b0, 1'b1);
    applyStimulus("add EX", C_EX_R, 1'b0, 1'b1);
    applyStimulus("add WB", C_WB_R, 1'b1, 1'b1);

    setInstr(6'b100011, 6'b000000, 1'b0);
    applyStimulus("lw IF", C_IF, 1'b0, 1'b1);
    applyStimulus("lw ID", C_ID, 1'b0, 1'b1);
    applyStimulus("lw EX", C_EX_I, 1'b0, 1'b1);
    applyStimulus("lw MEM wait1", C_MEM_LW, 1'b0, 1'b0);
    applyStimulus("lw MEM wait2", C_MEM_LW, 1'b0, 1'b0);
    applyStimulus("lw MEM wait3", C_MEM_LW, 1'b0, 1'b0);
    applyStimulus("lw MEM ready", C_MEM_LW, 1'b0, 1'b1);
    applyStimulus("lw WB", C_WB_LW, 1'b1, 1'b0);

    setInstr(6'b000100, 6'b000000, 1'b1);
    applyStimulus("beq z1 IF", C_IF, 1'b0, 1'b0);
    applyStimulus("beq z1 ID", C_ID, 1'b0, 1'b0);
    applyStimulus("beq z1 EX", C_EX_BEQ, 1'b1, 1'b0);
    setInstr(6'b000100, 6'b000000, 1'b0);
    applyStimulus("beq z0 IF", C_IF, 1'b0, 1'b0);
    applyStimulus("beq z0 ID", C_ID, 1'b0, 1'b0);
    applyStimulus("beq z0 EX", C_EX_BEQ, 1'b1, 1'b0);

    setInstr(6'b001000, 6'b111111, 1'b0);
    applyStimulus("addi IF", C_IF, 1'b0, 1'b1);
    applyStimulus("addi ID", C_ID, 1'b0, 1'b1);
    applyStimulus("addi EX", C_EX_I, 1'b0, 1'b1);
    applyStimulus("addi WB", C_WB_ADDI, 1'b1, 1'b1);

    setInstr(6'b101011, 6'b000000, 1'b0);
    applyStimulus("sw IF", C_IF, 1'b0, 1'b0);
    applyStimulus("sw ID", C_ID, 1'b0, 1'b0);
    applyStimulus("sw EX", C_EX_I, 1'b0, 1'b0);
    applyStimulus("sw MEM ready", C_MEM_SW, 1'b1, 1'b1);

    doJump("j");

    setInstr(6'b111111, 6'b000000, 1'b0);
    applyStimulus("badop IF", C_IF, 1'b0, 1'b0);
    applyStimulus("badop ID", C_ID, 1'b0, 1'b0);
    applyStimulus("badop ERR0", C_ERR, 1'b0, 1'b1);
    applyStimulus("badop ERR1", C_ERR, 1'b0, 1'b0);
    doReset("badop reset clears Fault");

    setInstr(6'b000000, 6'b000001, 1'b0);
    applyStimulus("badfn IF", C_IF, 1'b0, 1'b0);
    applyStimulus("badfn ID", C_ID, 1'b0, 1'b0);
    applyStimulus("badfn ERR", C_ERR, 1'b0, 1'b0);
    doReset("badfn reset");

    setInstr(6'b101011, 6'b000000, 1'b0);
    applyStimulus("swto IF", C_IF, 1'b0, 1'b0);
    applyStimulus("swto ID", C_ID, 1'b0, 1'b0);
    applyStimulus("swto EX", C_EX_I, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++)
      applyStimulus($sformatf("swto MEM%0d", i + 1), C_MEM_SW, 1'b0, 1'b0);
    applyStimulus("swto ERR0", C_ERR, 1'b0, 1'b0);
    applyStimulus("swto ERR1", C_ERR, 1'b0, 1'b1);
    doReset("swto reset");

    applyStimulus("swrst IF", C_IF, 1'b0, 1'b0);
    applyStimulus("swrst ID", C_ID, 1'b0, 1'b0);
    applyStimulus("swrst EX", C_EX_I, 1'b0, 1'b0);
    applyStimulus("swrst MEM1", C_MEM_SW, 1'b0, 1'b0);
    applyStimulus("swrst MEM2", C_MEM_SW, 1'b0, 1'b0);
    doReset("swrst mid-MEM drop");
    applyStimulus("swrst first IF", C_IF, 1'b0, 1'b0);
    applyStimulus("swrst then ID", C_ID, 1'b0, 1'b0);
    applyStimulus("swrst then EX", C_EX_I, 1'b0, 1'b0);
    applyStimulus("swrst then MEM", C_MEM_SW, 1'b1, 1'b1);

    // Long jump run drives both counters into saturation.
    for (int i = 0; i < 260; i++) doJump($sformatf("sat j%0d", i));

    for (int i = 0; i < 5 && expq.size() != 0; i++) @(negedge CLK);
    if (expq.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
